// File: rtl/memctrl_initiator.sv
// Single-outstanding read/write initiator driving the MEMCTRL strobe pins; reads return after RD_LAT strobed cycles.
// Requests are stalled (REQ_READY low) for the whole access, turnaround and any unconsumed response.
module memctrl_initiator #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int WR_CYC = 1,
  parameter int TURN   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              BUSY,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE,
  output logic              CSB,
  output logic              WEB,
  output logic              OEB,
  output logic [DATA_W-1:0] IDATA,
  input  logic [DATA_W-1:0] ODATA
);

  localparam int MAX_AW = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
  localparam int MAX_C  = (MAX_AW > TURN) ? MAX_AW : TURN;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_CYC);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RSP, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   idata_q, idata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic                ce_q, ce_d;
  logic                csb_q, csb_d;
  logic                web_q, web_d;
  logic                oeb_q, oeb_d;
  logic                req_rdy;
  logic                done;

  assign req_rdy   = (state_q == S_IDLE) && !RST;
  assign REQ_READY = req_rdy;
  assign BUSY      = (state_q != S_IDLE);
  assign RSP_VALID = rsp_vld_q;
  assign RSP_RDATA = rdata_q;
  assign ADDR      = addr_q;
  assign IDATA     = idata_q;
  assign CE        = ce_q;
  assign CSB       = csb_q;
  assign WEB       = web_q;
  assign OEB       = oeb_q;

  // Strobe flops are computed for the state being entered, so pins change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    idata_d   = idata_q;
    rdata_d   = rdata_q;
    rsp_vld_d = rsp_vld_q;
    ce_d      = 1'b0;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    oeb_d     = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID && req_rdy) begin
          addr_d  = REQ_ADDR;
          idata_d = REQ_WDATA;
          ce_d    = 1'b1;
          csb_d   = 1'b0;
          if (REQ_WE) begin
            state_d = S_WR;
            cnt_d   = WR_LD;
            web_d   = 1'b0;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LD;
            oeb_d   = 1'b0;
          end
        end
      end
      S_WR: begin
        if (cnt_q == CNT_ONE) begin
          done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          ce_d  = 1'b1;
          csb_d = 1'b0;
          web_d = 1'b0;
        end
      end
      S_RD: begin
        if (cnt_q == CNT_ONE) begin
          rdata_d   = ODATA;
          rsp_vld_d = 1'b1;
          state_d   = S_RSP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          ce_d  = 1'b1;
          csb_d = 1'b0;
          oeb_d = 1'b0;
        end
      end
      S_RSP: begin
        if (RSP_READY) begin
          rsp_vld_d = 1'b0;
          done      = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
    // With no turnaround configured the access ends straight back in IDLE.
    if (done) begin
      if (TURN == 0) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_GAP;
        cnt_d   = TURN_LD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      idata_q   <= '0;
      rdata_q   <= '0;
      rsp_vld_q <= 1'b0;
      ce_q      <= 1'b0;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      oeb_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      idata_q   <= idata_d;
      rdata_q   <= rdata_d;
      rsp_vld_q <= rsp_vld_d;
      ce_q      <= ce_d;
      csb_q     <= csb_d;
      web_q     <= web_d;
      oeb_q     <= oeb_d;
    end
  end

  a_no_wr_rd_overlap: assert property (@(posedge CLK) disable iff (RST) !(!csb_q && !web_q && !oeb_q));

endmodule

// File: tb/tb_memctrl_initiator.sv
// Directed bench for memctrl_initiator: default instance plus an RD_LAT=1/TURN=0 instance, each with a MEMCTRL memory model.
module tb_memctrl_initiator;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b0;

  logic        req_vld, req_rdy, req_we, rsp_vld, rsp_rdy, busy, ce, csb, web, oeb;
  logic [15:0] req_addr, addr;
  logic [7:0]  req_wdata, rsp_rdata, idata, odata;

  logic        req_vld1, req_rdy1, req_we1, rsp_vld1, rsp_rdy1, busy1, ce1, csb1, web1, oeb1;
  logic [15:0] req_addr1, addr1;
  logic [7:0]  req_wdata1, rsp_rdata1, idata1, odata1;

  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];

  always #5 clk = ~clk;

  memctrl_initiator u_dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_vld), .REQ_READY(req_rdy), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .RSP_VALID(rsp_vld), .RSP_READY(rsp_rdy),
    .RSP_RDATA(rsp_rdata), .BUSY(busy), .ADDR(addr), .CE(ce), .CSB(csb), .WEB(web),
    .OEB(oeb), .IDATA(idata), .ODATA(odata)
  );

  memctrl_initiator #(.RD_LAT(1), .TURN(0)) u_dut1 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_vld1), .REQ_READY(req_rdy1), .REQ_WE(req_we1),
    .REQ_ADDR(req_addr1), .REQ_WDATA(req_wdata1), .RSP_VALID(rsp_vld1), .RSP_READY(rsp_rdy1),
    .RSP_RDATA(rsp_rdata1), .BUSY(busy1), .ADDR(addr1), .CE(ce1), .CSB(csb1), .WEB(web1),
    .OEB(oeb1), .IDATA(idata1), .ODATA(odata1)
  );

  // MEMCTRL models: synchronous write, combinational read while selected with output enabled.
  always @(posedge clk) if (!csb && !web) mem0[addr] <= idata;
  always @(posedge clk) if (!csb1 && !web1) mem1[addr1] <= idata1;
  assign odata  = (!csb && !oeb) ? mem0[addr] : 8'h00;
  assign odata1 = (!csb1 && !oeb1) ? mem1[addr1] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_legal0", 32'(!csb && !web && !oeb), 0);
      check("strobe_legal1", 32'(!csb1 && !web1 && !oeb1), 0);
    end
  end

  // One full access on the default instance, checking occupancy / read latency and data.
  task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (!req_rdy && n < 20) begin tick(); n++; end
    check({tag, " ready"}, 32'(req_rdy), 1);
    req_vld = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    tick();
    req_vld = 1'b0;
    n = 1;
    if (we) begin
      while (!req_rdy && n < 20) begin tick(); n++; end
      check({tag, " wr occupancy"}, n, 3);
    end else begin
      while (!rsp_vld && n < 20) begin tick(); n++; end
      check({tag, " rd latency"}, n, 3);
      check({tag, " rdata"}, 32'(rsp_rdata), 32'(exp));
      tick();
      check({tag, " rsp drop"}, 32'(rsp_vld), 0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0001, 8'h3C, 8'h00};
    vecs[1] = '{1'b1, 16'h8000, 8'hC3, 8'h00};
    vecs[2] = '{1'b0, 16'hFFFF, 8'h00, 8'h22};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 8'h11};
    vecs[4] = '{1'b0, 16'h0001, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 16'h8000, 8'h00, 8'hC3};
    vecs[6] = '{1'b1, 16'h1234, 8'h00, 8'h00};
    vecs[7] = '{1'b0, 16'h1234, 8'h00, 8'h00};

    rst = 1'b1;
    req_vld = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_rdy = 1;
    req_vld1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0; rsp_rdy1 = 1;
    tick(); tick();
    mon_en = 1'b1;

    // Reset state
    check("rst strobes", 32'({ce, csb, web, oeb}), 32'(4'b0111));
    check("rst addr", 32'(addr), 0);
    check("rst idata", 32'(idata), 0);
    check("rst rsp_valid", 32'(rsp_vld), 0);
    check("rst rsp_rdata", 32'(rsp_rdata), 0);
    check("rst busy", 32'(busy), 0);
    check("rst req_ready", 32'(req_rdy), 0);
    rst = 1'b0;
    tick();
    check("post-rst req_ready", 32'(req_rdy), 1);

    // 1: single write
    req_vld = 1; req_we = 1; req_addr = 16'h1234; req_wdata = 8'hA5;
    tick();
    req_vld = 0;
    check("t1 strobes", 32'({ce, csb, web, oeb}), 32'(4'b1001));
    check("t1 addr", 32'(addr), 'h1234);
    check("t1 idata", 32'(idata), 'hA5);
    check("t1 busy", 32'(busy), 1);
    tick();
    check("t1 gap strobes", 32'({ce, csb, web, oeb}), 32'(4'b0111));
    check("t1 gap ready", 32'(req_rdy), 0);
    tick();
    check("t1 ready", 32'(req_rdy), 1);

    // 2: read back with response consumed immediately
    req_vld = 1; req_we = 0; req_addr = 16'h1234;
    tick();
    req_vld = 0;
    check("t2 rd1 strobes", 32'({ce, csb, web, oeb}), 32'(4'b1010));
    tick();
    check("t2 rd2 strobes", 32'({ce, csb, web, oeb}), 32'(4'b1010));
    check("t2 no early rsp", 32'(rsp_vld), 0);
    tick();
    check("t2 rsp_valid", 32'(rsp_vld), 1);
    check("t2 rsp_rdata", 32'(rsp_rdata), 'hA5);
    check("t2 rsp strobes", 32'({ce, csb, web, oeb}), 32'(4'b0111));
    tick();
    check("t2 rsp drop", 32'(rsp_vld), 0);
    check("t2 gap ready", 32'(req_rdy), 0);
    tick();
    check("t2 ready", 32'(req_rdy), 1);

    // 3: response stalled by RSP_READY low, new request held off
    rsp_rdy = 0;
    req_vld = 1; req_we = 0; req_addr = 16'h1234;
    tick();
    req_vld = 0;
    tick(); tick();
    check("t3 rsp_valid", 32'(rsp_vld), 1);
    req_vld = 1; req_we = 1; req_addr = 16'h0042; req_wdata = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3 held valid", 32'(rsp_vld), 1);
      check("t3 held rdata", 32'(rsp_rdata), 'hA5);
      check("t3 no accept", 32'({req_rdy, csb}), 1);
    end
    req_vld = 0;
    rsp_rdy = 1;
    tick();
    check("t3 rsp drop", 32'(rsp_vld), 0);
    check("t3 gap ready", 32'(req_rdy), 0);
    tick();
    check("t3 ready", 32'(req_rdy), 1);

    // 4: back-to-back writes with REQ_VALID held
    req_vld = 1; req_we = 1; req_addr = 16'h0000; req_wdata = 8'h11;
    tick();
    check("t4 w0 strobes", 32'({ce, csb, web, oeb}), 32'(4'b1001));
    check("t4 w0 addr", 32'(addr), 'h0000);
    req_addr = 16'hFFFF; req_wdata = 8'h22;
    tick();
    check("t4 gap ready", 32'(req_rdy), 0);
    tick();
    check("t4 ready 3rd cycle", 32'(req_rdy), 1);
    tick();
    req_vld = 0;
    check("t4 w1 strobes", 32'({ce, csb, web, oeb}), 32'(4'b1001));
    check("t4 w1 addr", 32'(addr), 'hFFFF);
    check("t4 w1 idata", 32'(idata), 'h22);
    tick(); tick();

    // 5: reset during the second read cycle
    check("t5 ready", 32'(req_rdy), 1);
    req_vld = 1; req_we = 0; req_addr = 16'h0000;
    tick();
    req_vld = 0;
    check("t5 rd1 strobes", 32'({ce, csb, web, oeb}), 32'(4'b1010));
    tick();
    rst = 1;
    tick();
    check("t5 rst strobes", 32'({ce, csb, web, oeb}), 32'(4'b0111));
    check("t5 rst rsp_valid", 32'(rsp_vld), 0);
    check("t5 rst busy", 32'(busy), 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5 no rsp", 32'(rsp_vld), 0);
    end
    access(1'b0, 16'h1234, 8'h00, 8'hA5, "t5 clean read");

    // Table of accesses, including address extremes written in test 4
    for (int i = 0; i < 8; i++)
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // 6: RD_LAT=1, TURN=0 instance
    check("t6 ready", 32'(req_rdy1), 1);
    req_vld1 = 1; req_we1 = 1; req_addr1 = 16'h0055; req_wdata1 = 8'h77;
    tick();
    req_vld1 = 0;
    check("t6 wr strobes", 32'({ce1, csb1, web1, oeb1}), 32'(4'b1001));
    tick();
    check("t6 wr occupancy", 32'(req_rdy1), 1);
    req_vld1 = 1; req_we1 = 0;
    tick();
    req_vld1 = 0;
    check("t6 rd strobes", 32'({ce1, csb1, web1, oeb1}), 32'(4'b1010));
    check("t6 no early rsp", 32'(rsp_vld1), 0);
    tick();
    check("t6 rsp_valid", 32'(rsp_vld1), 1);
    check("t6 rsp_rdata", 32'(rsp_rdata1), 'h77);
    check("t6 rsp strobes", 32'({ce1, csb1, web1, oeb1}), 32'(4'b0111));
    tick();
    check("t6 rsp drop", 32'(rsp_vld1), 0);
    check("t6 ready no gap", 32'(req_rdy1), 1);

    tick();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
